// File: rtl/lut2_1134.sv
// 8x8 unsigned approximate multiplier built from sixteen 2x2 digit cells.
// Low-weight digit pairs use a lossy 3-bit cell (3x3 -> 7); the result is registered.
module lut2_1134 #(
    parameter int N            = 8,
    parameter int APPROX_LIMIT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    output logic [15:0]   prod8,
    output logic          out_valid
);

    localparam int DIGITS = N / 2;

    function automatic logic [3:0] cell_exact(input logic [1:0] x, input logic [1:0] y);
        return 4'(x) * 4'(y);
    endfunction

    // Dropping the 8's bit saves a LUT output; only 3x3 is affected (9 becomes 7).
    function automatic logic [2:0] cell_approx(input logic [1:0] x, input logic [1:0] y);
        logic [3:0] p;
        p = 4'(x) * 4'(y);
        return (x == 2'd3 && y == 2'd3) ? 3'b111 : p[2:0];
    endfunction

    logic [15:0] result;

    always_comb begin
        logic [3:0] pp;
        result = 16'h0000;
        for (int i = 0; i < DIGITS; i++) begin
            for (int j = 0; j < DIGITS; j++) begin
                if (i + j <= APPROX_LIMIT)
                    pp = {1'b0, cell_approx(a[2*i +: 2], b[2*j +: 2])};
                else
                    pp = cell_exact(a[2*i +: 2], b[2*j +: 2]);
                result = result + (16'(pp) << (2 * (i + j)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod8     <= 16'h0000;
            out_valid <= 1'b0;
        end else begin
            if (in_valid)
                prod8 <= result;
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_lut2_1134.sv
// Directed and exhaustive check of lut2_1134 against an error-term model of the
// approximation: exact product minus the loss of each lossy 3x3 digit pair.
module tb_lut2_1134;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod8;
    logic        out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] p;
        logic        v;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] last_prod = 16'h0000;

    lut2_1134 dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .prod8    (prod8),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Each lossy cell hit with 3x3 loses 2 at its digit weight.
    function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
        int exact;
        int err;
        exact = int'(x) * int'(y);
        err = 0;
        if (x[1:0] == 2'd3 && y[1:0] == 2'd3) err += 2;
        if (x[1:0] == 2'd3 && y[3:2] == 2'd3) err += 8;
        if (x[3:2] == 2'd3 && y[1:0] == 2'd3) err += 8;
        return 16'(exact - err);
    endfunction

    task automatic step(input logic r, input logic v, input logic [7:0] x,
                        input logic [7:0] y, input string tag);
        exp_t e;
        exp_t got;
        int   exact;
        rst      = r;
        in_valid = v;
        a        = x;
        b        = y;
        if (r) begin
            e.p = 16'h0000;
            e.v = 1'b0;
        end else begin
            e.p = v ? model(x, y) : last_prod;
            e.v = v;
        end
        last_prod = e.p;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        n_checks++;
        assert (prod8 === got.p) else begin
            n_fail++;
            $error("FAIL %s prod8 a=%0d b=%0d observed=%0d expected=%0d", tag, x, y, prod8, got.p);
        end
        n_checks++;
        assert (out_valid === got.v) else begin
            n_fail++;
            $error("FAIL %s out_valid observed=%0b expected=%0b", tag, out_valid, got.v);
        end
        if (!r && v) begin
            exact = int'(x) * int'(y);
            n_checks++;
            assert (int'(prod8) <= exact && exact - int'(prod8) <= 18) else begin
                n_fail++;
                $error("FAIL %s err_bound a=%0d b=%0d observed=%0d exact=%0d", tag, x, y, prod8, exact);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00;
        step(1'b1, 1'b0, 8'd0, 8'd0, "reset_idle");
        step(1'b1, 1'b1, 8'd255, 8'd255, "reset_prio");
        step(1'b0, 1'b1, 8'd255, 8'd255, "max_after_reset");

        step(1'b0, 1'b1, 8'd3, 8'd3, "approx_3x3");
        step(1'b0, 1'b1, 8'd12, 8'd3, "approx_12x3");
        step(1'b0, 1'b1, 8'd3, 8'd12, "approx_3x12");

        step(1'b0, 1'b1, 8'd48, 8'd3, "exact_48x3");
        step(1'b0, 1'b1, 8'd1, 8'd200, "exact_1x200");
        step(1'b0, 1'b1, 8'd0, 8'd255, "zero_a");
        step(1'b0, 1'b1, 8'd255, 8'd0, "zero_b");
        step(1'b0, 1'b1, 8'd128, 8'd128, "exact_128x128");
        step(1'b0, 1'b1, 8'd15, 8'd15, "max_err_15x15");

        step(1'b0, 1'b1, 8'd10, 8'd10, "hold_load");
        step(1'b0, 1'b0, 8'd255, 8'd255, "hold_idle");
        step(1'b0, 1'b0, 8'd7, 8'd9, "hold_idle2");

        step(1'b0, 1'b1, 8'd2, 8'd3, "b2b_0");
        step(1'b0, 1'b1, 8'd3, 8'd3, "b2b_1");
        step(1'b0, 1'b1, 8'd255, 8'd255, "b2b_2");

        step(1'b1, 1'b1, 8'd200, 8'd100, "reset_mid");
        step(1'b0, 1'b0, 8'd200, 8'd100, "idle_after_reset");

        for (int i = 0; i < 256; i++)
            for (int j = 0; j < 256; j++)
                step(1'b0, 1'b1, 8'(i), 8'(j), "exhaustive");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
